// File: rtl/cam_pkg.sv
// Shared definitions for the frame colour counter: default geometry,
// RGB111 pixel codes, colour ids and the scan FSM state encoding.
package cam_pkg;

    localparam int AW   = 15;
    localparam int DW   = 3;
    localparam int NPIX = 19200;

    localparam logic [2:0] PIX_RED   = 3'b100;
    localparam logic [2:0] PIX_GREEN = 3'b010;
    localparam logic [2:0] PIX_BLUE  = 3'b001;

    localparam logic [1:0] CID_NONE  = 2'd0;
    localparam logic [1:0] CID_RED   = 2'd1;
    localparam logic [1:0] CID_GREEN = 2'd2;
    localparam logic [1:0] CID_BLUE  = 2'd3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SCAN   = 3'd1,
        DRAIN  = 3'd2,
        DECIDE = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/color_argmax.sv
// Combinational dominant-colour pick: a colour wins only when it reaches
// THRESH and strictly beats both other counts; ties or low counts give none.
module color_argmax #(
    parameter int CW     = 16,
    parameter int THRESH = 1920
) (
    input  logic [CW-1:0] red_cnt,
    input  logic [CW-1:0] green_cnt,
    input  logic [CW-1:0] blue_cnt,
    output logic [1:0]    color_id
);
    import cam_pkg::*;

    localparam logic [31:0] THR = THRESH;

    logic red_win;
    logic green_win;
    logic blue_win;

    always_comb begin
        red_win   = (32'(red_cnt) >= THR) && (red_cnt > green_cnt) && (red_cnt > blue_cnt);
        green_win = (32'(green_cnt) >= THR) && (green_cnt > red_cnt) && (green_cnt > blue_cnt);
        blue_win  = (32'(blue_cnt) >= THR) && (blue_cnt > red_cnt) && (blue_cnt > green_cnt);

        color_id = CID_NONE;
        if (red_win) begin
            color_id = CID_RED;
        end else if (green_win) begin
            color_id = CID_GREEN;
        end else if (blue_win) begin
            color_id = CID_BLUE;
        end
    end

endmodule

// File: rtl/frame_color_counter.sv
// Scans one frame from a 1-cycle-latency frame buffer, counts pure red/green/blue
// pixels and reports the per-colour counts plus the dominant colour.
//
// state  | meaning
// IDLE   | waiting for start; results hold
// SCAN   | issuing addresses 0..NPIX-1, capturing the pixel from the previous address
// DRAIN  | capturing the last pixel, address holds at NPIX-1
// DECIDE | counts final; results and done registered on the way out
// DONE   | done pulse cycle, results visible
module frame_color_counter #(
    parameter int AW     = cam_pkg::AW,
    parameter int DW     = cam_pkg::DW,
    parameter int NPIX   = cam_pkg::NPIX,
    parameter int THRESH = 1920
) (
    input  logic          P_clk,
    input  logic          reset,
    input  logic          start,
    output logic [AW-1:0] addr_r,
    input  logic [DW-1:0] data_r,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   red_cnt,
    output logic [AW:0]   green_cnt,
    output logic [AW:0]   blue_cnt,
    output logic [1:0]    color_id
);
    import cam_pkg::*;

    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

    state_t      state;
    logic [AW:0] red_acc;
    logic [AW:0] green_acc;
    logic [AW:0] blue_acc;
    logic [1:0]  id_next;
    logic        is_red;
    logic        is_green;
    logic        is_blue;

    always_comb begin
        is_red   = (data_r == DW'(PIX_RED));
        is_green = (data_r == DW'(PIX_GREEN));
        is_blue  = (data_r == DW'(PIX_BLUE));
    end

    color_argmax #(
        .CW     (AW + 1),
        .THRESH (THRESH)
    ) u_argmax (
        .red_cnt   (red_acc),
        .green_cnt (green_acc),
        .blue_cnt  (blue_acc),
        .color_id  (id_next)
    );

    always_ff @(posedge P_clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            addr_r    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            red_acc   <= '0;
            green_acc <= '0;
            blue_acc  <= '0;
            red_cnt   <= '0;
            green_cnt <= '0;
            blue_cnt  <= '0;
            color_id  <= CID_NONE;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SCAN;
                        busy      <= 1'b1;
                        addr_r    <= '0;
                        red_acc   <= '0;
                        green_acc <= '0;
                        blue_acc  <= '0;
                    end
                end
                SCAN: begin
                    // data_r is only meaningful once address 0 has been out for a cycle
                    if (addr_r != '0) begin
                        if (is_red)   red_acc   <= red_acc + 1'b1;
                        if (is_green) green_acc <= green_acc + 1'b1;
                        if (is_blue)  blue_acc  <= blue_acc + 1'b1;
                    end
                    if (addr_r == LAST_ADDR) begin
                        state <= DRAIN;
                    end else begin
                        addr_r <= addr_r + 1'b1;
                    end
                end
                DRAIN: begin
                    if (is_red)   red_acc   <= red_acc + 1'b1;
                    if (is_green) green_acc <= green_acc + 1'b1;
                    if (is_blue)  blue_acc  <= blue_acc + 1'b1;
                    state <= DECIDE;
                end
                DECIDE: begin
                    red_cnt   <= red_acc;
                    green_cnt <= green_acc;
                    blue_cnt  <= blue_acc;
                    color_id  <= id_next;
                    done      <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_color_counter.sv
// Directed bench for frame_color_counter with a 16-pixel frame, THRESH=4 and a
// 1-cycle-latency RAM model; expected counts and ids are hand-computed per frame.
module tb_frame_color_counter;

    localparam int AW     = 4;
    localparam int DW     = 3;
    localparam int NPIX   = 16;
    localparam int THRESH = 4;

    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] GREEN = 3'b010;
    localparam logic [2:0] BLUE  = 3'b001;
    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] WHITE = 3'b111;
    localparam logic [2:0] MIXED = 3'b110;

    logic          P_clk;
    logic          reset;
    logic          start;
    logic [AW-1:0] addr_r;
    logic [DW-1:0] data_r;
    logic          busy;
    logic          done;
    logic [AW:0]   red_cnt;
    logic [AW:0]   green_cnt;
    logic [AW:0]   blue_cnt;
    logic [1:0]    color_id;

    logic [2:0] mem [NPIX];

    int n_vec;
    int n_err;
    int done_cnt;
    int prev_r;
    int prev_g;
    int prev_b;

    frame_color_counter #(
        .AW     (AW),
        .DW     (DW),
        .NPIX   (NPIX),
        .THRESH (THRESH)
    ) dut (
        .P_clk     (P_clk),
        .reset     (reset),
        .start     (start),
        .addr_r    (addr_r),
        .data_r    (data_r),
        .busy      (busy),
        .done      (done),
        .red_cnt   (red_cnt),
        .green_cnt (green_cnt),
        .blue_cnt  (blue_cnt),
        .color_id  (color_id)
    );

    initial begin
        P_clk = 1'b0;
        forever #5 P_clk = ~P_clk;
    end

    always @(posedge P_clk) data_r <= mem[addr_r];

    always @(negedge P_clk) if (done) done_cnt++;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Pixels are scattered over the frame with stride 5 (a permutation of 0..15)
    task automatic load_frame(input int nr, input int ng, input int nb, input logic [2:0] fill);
        for (int i = 0; i < NPIX; i++) begin
            logic [2:0] v;
            if (i < nr)                v = RED;
            else if (i < nr + ng)      v = GREEN;
            else if (i < nr + ng + nb) v = BLUE;
            else                       v = fill;
            mem[(i * 5) % NPIX] = v;
        end
    endtask

    task automatic chk_results(input string tag, input int er, input int eg, input int eb, input int eid);
        chk({tag, "_red"},   int'(red_cnt),   er);
        chk({tag, "_green"}, int'(green_cnt), eg);
        chk({tag, "_blue"},  int'(blue_cnt),  eb);
        chk({tag, "_id"},    int'(color_id),  eid);
    endtask

    task automatic do_scan(input string tag, input int er, input int eg, input int eb,
                           input int eid, input int extra_at);
        int n;
        int base;
        base = done_cnt;
        @(negedge P_clk) start = 1'b1;
        @(negedge P_clk) start = 1'b0;
        n = 1;
        while (!done && n < 40) begin
            if (n <= 18) chk({tag, "_addr"}, int'(addr_r), (n - 1 > NPIX - 1) ? NPIX - 1 : n - 1);
            if (n == 10) chk_results({tag, "_hold"}, prev_r, prev_g, prev_b,
                                     (prev_r >= THRESH && prev_r > prev_g && prev_r > prev_b) ? 1 :
                                     (prev_g >= THRESH && prev_g > prev_r && prev_g > prev_b) ? 2 :
                                     (prev_b >= THRESH && prev_b > prev_r && prev_b > prev_g) ? 3 : 0);
            if (n == extra_at)     start = 1'b1;
            if (n == extra_at + 1) start = 1'b0;
            @(negedge P_clk);
            n++;
        end
        chk({tag, "_done_cycle"}, n, 19);
        chk({tag, "_busy_in_done"}, int'(busy), 1);
        chk_results(tag, er, eg, eb, eid);
        @(negedge P_clk);
        chk({tag, "_done_pulse"}, int'(done), 0);
        chk({tag, "_busy_after"}, int'(busy), 0);
        repeat (3) @(negedge P_clk);
        chk({tag, "_busy_idle"}, int'(busy), 0);
        chk({tag, "_done_count"}, done_cnt - base, 1);
        prev_r = er;
        prev_g = eg;
        prev_b = eb;
    endtask

    initial begin
        int n;
        int base;
        int t_done [3];
        int k;
        int er [3];
        int eg [3];
        int eb [3];
        int eid [3];

        n_vec    = 0;
        n_err    = 0;
        done_cnt = 0;
        prev_r   = 0;
        prev_g   = 0;
        prev_b   = 0;
        reset    = 1'b0;
        start    = 1'b0;
        load_frame(0, 0, 0, BLACK);

        repeat (3) @(negedge P_clk);
        chk("rst_addr", int'(addr_r), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk_results("rst", 0, 0, 0, 0);
        reset = 1'b1;
        repeat (2) @(negedge P_clk);
        chk("post_rst_busy", int'(busy), 0);

        load_frame(10, 3, 3, BLACK);
        do_scan("f_red", 10, 3, 3, 1, -10);

        load_frame(0, 6, 6, BLACK);
        do_scan("f_tie", 0, 6, 6, 0, 5);

        load_frame(0, 0, 3, WHITE);
        do_scan("f_low", 0, 0, 3, 0, -10);

        load_frame(0, 16, 0, BLACK);
        do_scan("f_full", 0, 16, 0, 2, -10);

        // Abort a scan with reset in cycle 8
        load_frame(0, 6, 6, BLACK);
        base = done_cnt;
        @(negedge P_clk) start = 1'b1;
        @(negedge P_clk) start = 1'b0;
        repeat (7) @(negedge P_clk);
        reset = 1'b0;
        #1;
        chk("abort_addr", int'(addr_r), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk_results("abort", 0, 0, 0, 0);
        @(negedge P_clk) reset = 1'b1;
        repeat (25) @(negedge P_clk);
        chk("abort_no_done", done_cnt - base, 0);
        chk("abort_idle", int'(busy), 0);
        prev_r = 0;
        prev_g = 0;
        prev_b = 0;

        load_frame(3, 3, 4, MIXED);
        do_scan("f_thr", 3, 3, 4, 3, -10);

        // Back-to-back frames with start held high
        er[0] = 10; eg[0] = 3;  eb[0] = 3; eid[0] = 1;
        er[1] = 0;  eg[1] = 16; eb[1] = 0; eid[1] = 2;
        er[2] = 3;  eg[2] = 3;  eb[2] = 4; eid[2] = 3;
        load_frame(10, 3, 3, BLACK);
        base = done_cnt;
        k = 0;
        n = 0;
        @(negedge P_clk) start = 1'b1;
        while (k < 3 && n < 100) begin
            @(negedge P_clk);
            n++;
            if (done) begin
                t_done[k] = n;
                chk_results($sformatf("b2b%0d", k), er[k], eg[k], eb[k], eid[k]);
                if (k == 0) load_frame(0, 16, 0, BLACK);
                if (k == 1) load_frame(3, 3, 4, MIXED);
                if (k == 2) start = 1'b0;
                k++;
            end
        end
        start = 1'b0;
        chk("b2b_count", k, 3);
        if (k == 3) begin
            chk("b2b_first", t_done[0], 19);
            chk("b2b_gap1", t_done[1] - t_done[0], 20);
            chk("b2b_gap2", t_done[2] - t_done[1], 20);
        end
        repeat (25) @(negedge P_clk);
        chk("b2b_total_done", done_cnt - base, 3);
        chk("b2b_idle", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
